register_read_stage: RTL and testbench

Read side of the 64-bit register file: takes two source-register numbers per request, snapshots their values from the register bank, and hands them downstream through a 2-entry valid/ready buffer. Sits between decode and execute, opposite the per-register write path. Includes write-to-read bypass so a read and a write to the same register in one cycle return the newly written value. Register 31 always reads as zero.

---
 rtl/register_read_stage.sv | 115 +++++++++++
 tb/tb_register_read_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_read_stage.sv
// Read side of the register file: resolves two source operands per request
// (zero register, write bypass, bank value) and buffers them in a 2-entry queue.
module register_read_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regContents,
  input  logic                           wrEnable,
  input  logic [ADDR_WIDTH-1:0]          wrReg,
  input  logic [DATA_WIDTH-1:0]          wrData,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic [ADDR_WIDTH-1:0]          readRegA,
  input  logic [ADDR_WIDTH-1:0]          readRegB,
  output logic                           rspValid,
  input  logic                           rspReady,
  output logic [DATA_WIDTH-1:0]          readDataA,
  output logic [DATA_WIDTH-1:0]          readDataB
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(31);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] headA_q, headA_d, headB_q, headB_d;
  logic [DATA_WIDTH-1:0] tailA_q, tailA_d, tailB_q, tailB_d;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] newA, newB;
  logic                  push, pop;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs[k] = regContents[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Priority: zero register beats bypass, bypass beats the bank value.
  always_comb begin
    newA = regs[readRegA];
    if (wrEnable && (wrReg != ZERO_REG) && (wrReg == readRegA)) newA = wrData;
    if (readRegA == ZERO_REG) newA = '0;
    newB = regs[readRegB];
    if (wrEnable && (wrReg != ZERO_REG) && (wrReg == readRegB)) newB = wrData;
    if (readRegB == ZERO_REG) newB = '0;
  end

  assign reqReady  = (state_q != FULL);
  assign rspValid  = (state_q != EMPTY);
  assign readDataA = rspValid ? headA_q : '0;
  assign readDataB = rspValid ? headB_q : '0;
  assign push      = reqValid & reqReady;
  assign pop       = rspValid & rspReady;

  always_comb begin
    state_d = state_q;
    headA_d = headA_q;
    headB_d = headB_q;
    tailA_d = tailA_q;
    tailB_d = tailB_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          headA_d = newA;
          headB_d = newB;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          headA_d = newA;
          headB_d = newB;
        end else if (push) begin
          tailA_d = newA;
          tailB_d = newB;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          headA_d = tailA_q;
          headB_d = tailB_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      headA_q <= '0;
      headB_q <= '0;
      tailA_q <= '0;
      tailB_q <= '0;
    end else begin
      state_q <= state_d;
      headA_q <= headA_d;
      headB_q <= headB_d;
      tailA_q <= tailA_d;
      tailB_q <= tailB_d;
    end
  end

endmodule

// File: tb/tb_register_read_stage.sv
// Directed self-checking bench for register_read_stage.
module tb_register_read_stage;

  logic          clk;
  logic          reset;
  logic [2047:0] regContents;
  logic          wrEnable;
  logic [4:0]    wrReg;
  logic [63:0]   wrData;
  logic          reqValid;
  logic          reqReady;
  logic [4:0]    readRegA;
  logic [4:0]    readRegB;
  logic          rspValid;
  logic          rspReady;
  logic [63:0]   readDataA;
  logic [63:0]   readDataB;

  logic [63:0]   regs [32];
  int            passed;
  int            total;

  register_read_stage #(
    .DATA_WIDTH(64),
    .NUM_REGS  (32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .regContents(regContents),
    .wrEnable   (wrEnable),
    .wrReg      (wrReg),
    .wrData     (wrData),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .readRegA   (readRegA),
    .readRegB   (readRegB),
    .rspValid   (rspValid),
    .rspReady   (rspReady),
    .readDataA  (readDataA),
    .readDataB  (readDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    regContents = '0;
    for (int k = 0; k < 32; k++) regContents[k*64 +: 64] = regs[k];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++; if (rspValid !== 1'b0) $display("FAIL reset_rspValid: got %b want 0", rspValid); else passed++;
    total++; if (reqReady !== 1'b1) $display("FAIL reset_reqReady: got %b want 1", reqReady); else passed++;
    total++; if (readDataA !== 64'h0) $display("FAIL reset_dataA: got %h want 0", readDataA); else passed++;
    total++; if (readDataB !== 64'h0) $display("FAIL reset_dataB: got %h want 0", readDataB); else passed++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    regs[3]  = 64'h1234;
    regs[31] = 64'hFFFF_FFFF;
    rspReady = 1'b1;
    readRegA = 5'd3;
    readRegB = 5'd31;
    reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    total++; if (rspValid !== 1'b1) $display("FAIL basic_rspValid: got %b want 1", rspValid); else passed++;
    total++; if (readDataA !== 64'h1234) $display("FAIL basic_dataA: got %h want 1234", readDataA); else passed++;
    total++; if (readDataB !== 64'h0) $display("FAIL basic_dataB_zero_reg: got %h want 0", readDataB); else passed++;
    step();
    total++; if (rspValid !== 1'b0) $display("FAIL basic_drain: got %b want 0", rspValid); else passed++;
  endtask

  task automatic test_bypass();
    regs[5]  = 64'h0;
    wrEnable = 1'b1;
    wrReg    = 5'd5;
    wrData   = 64'hDEAD_BEEF;
    readRegA = 5'd5;
    readRegB = 5'd5;
    reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    wrEnable = 1'b0;
    total++; if (readDataA !== 64'hDEAD_BEEF) $display("FAIL bypass_dataA: got %h want deadbeef", readDataA); else passed++;
    total++; if (readDataB !== 64'hDEAD_BEEF) $display("FAIL bypass_dataB: got %h want deadbeef", readDataB); else passed++;
    step();
    regs[31] = 64'h5555;
    regs[6]  = 64'h66;
    wrEnable = 1'b1;
    wrReg    = 5'd31;
    wrData   = 64'hCAFE;
    readRegA = 5'd31;
    readRegB = 5'd6;
    reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    wrEnable = 1'b0;
    total++; if (readDataA !== 64'h0) $display("FAIL bypass_r31_dataA: got %h want 0", readDataA); else passed++;
    total++; if (readDataB !== 64'h66) $display("FAIL bypass_r31_dataB: got %h want 66", readDataB); else passed++;
    step();
  endtask

  task automatic test_backpressure();
    regs[1]  = 64'h11;
    regs[2]  = 64'h22;
    regs[4]  = 64'h44;
    rspReady = 1'b0;
    reqValid = 1'b1;
    readRegA = 5'd1; readRegB = 5'd1;
    total++; if (reqReady !== 1'b1) $display("FAIL bp_ready_first: got %b want 1", reqReady); else passed++;
    step();
    readRegA = 5'd2; readRegB = 5'd2;
    total++; if (reqReady !== 1'b1) $display("FAIL bp_ready_second: got %b want 1", reqReady); else passed++;
    step();
    readRegA = 5'd4; readRegB = 5'd4;
    total++; if (reqReady !== 1'b0) $display("FAIL bp_ready_third: got %b want 0", reqReady); else passed++;
    total++; if (readDataA !== 64'h11) $display("FAIL bp_head_first: got %h want 11", readDataA); else passed++;
    step();
    total++; if (readDataA !== 64'h11) $display("FAIL bp_head_hold: got %h want 11", readDataA); else passed++;
    total++; if (rspValid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", rspValid); else passed++;
    rspReady = 1'b1;
    step();
    total++; if (readDataA !== 64'h22) $display("FAIL bp_out_second: got %h want 22", readDataA); else passed++;
    total++; if (reqReady !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", reqReady); else passed++;
    step();
    reqValid = 1'b0;
    total++; if (readDataA !== 64'h44) $display("FAIL bp_out_third: got %h want 44", readDataA); else passed++;
    total++; if (rspValid !== 1'b1) $display("FAIL bp_valid_third: got %b want 1", rspValid); else passed++;
    step();
    total++; if (rspValid !== 1'b0) $display("FAIL bp_no_duplicate: got %b want 0", rspValid); else passed++;
  endtask

  task automatic test_snapshot();
    regs[7]  = 64'h7;
    regs[0]  = 64'hAB;
    rspReady = 1'b0;
    readRegA = 5'd7; readRegB = 5'd0;
    reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    regs[7]  = 64'h99;
    wrEnable = 1'b1; wrReg = 5'd7; wrData = 64'h99;
    step();
    wrEnable = 1'b0;
    total++; if (readDataA !== 64'h7) $display("FAIL snap_head_kept: got %h want 7", readDataA); else passed++;
    reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    total++; if (readDataA !== 64'h7) $display("FAIL snap_head_still: got %h want 7", readDataA); else passed++;
    total++; if (readDataB !== 64'hAB) $display("FAIL snap_head_B: got %h want ab", readDataB); else passed++;
    rspReady = 1'b1;
    step();
    total++; if (readDataA !== 64'h99) $display("FAIL snap_new_value: got %h want 99", readDataA); else passed++;
    step();
    total++; if (rspValid !== 1'b0) $display("FAIL snap_drain: got %b want 0", rspValid); else passed++;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      regs[8+i]  = 64'h1000 + 64'(i);
      regs[16+i] = 64'h2000 + 64'(i);
    end
    rspReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      readRegA = 5'(8 + i);
      readRegB = 5'(16 + i);
      reqValid = 1'b1;
      total++; if (reqReady !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, reqReady); else passed++;
      step();
      total++; if (rspValid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, rspValid); else passed++;
      total++; if (readDataA !== 64'h1000 + 64'(i)) $display("FAIL stream_dataA[%0d]: got %h want %h", i, readDataA, 64'h1000 + 64'(i)); else passed++;
      total++; if (readDataB !== 64'h2000 + 64'(i)) $display("FAIL stream_dataB[%0d]: got %h want %h", i, readDataB, 64'h2000 + 64'(i)); else passed++;
    end
    reqValid = 1'b0;
    step();
    total++; if (rspValid !== 1'b0) $display("FAIL stream_drain: got %b want 0", rspValid); else passed++;
  endtask

  task automatic test_reset_full();
    rspReady = 1'b0;
    reqValid = 1'b1;
    readRegA = 5'd1; readRegB = 5'd2;
    step();
    step();
    reqValid = 1'b0;
    total++; if (reqReady !== 1'b0) $display("FAIL rstfull_is_full: got %b want 0", reqReady); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (rspValid !== 1'b0) $display("FAIL rstfull_rspValid: got %b want 0", rspValid); else passed++;
    total++; if (reqReady !== 1'b1) $display("FAIL rstfull_reqReady: got %b want 1", reqReady); else passed++;
    total++; if (readDataA !== 64'h0) $display("FAIL rstfull_dataA: got %h want 0", readDataA); else passed++;
    total++; if (readDataB !== 64'h0) $display("FAIL rstfull_dataB: got %h want 0", readDataB); else passed++;
    step();
    reset = 1'b0;
    rspReady = 1'b1;
    step();
    total++; if (rspValid !== 1'b0) $display("FAIL rstfull_discarded: got %b want 0", rspValid); else passed++;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    reset    = 1'b0;
    wrEnable = 1'b0;
    wrReg    = '0;
    wrData   = '0;
    reqValid = 1'b0;
    readRegA = '0;
    readRegB = '0;
    rspReady = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 64'h0;
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_snapshot();
    test_streaming();
    test_reset_full();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
